// File: rtl/rx_os_collector.sv
// rx_os_collector: gathers per-lane 128b/130b ordered-set blocks and emits them as one wide, aligned set.
// Optional feature: define RX_OS_SKP_FILTER_EN to drop completed SKP sets (lane 0 symbol 0 == 8'hAA).
module rx_os_collector #(
    parameter int LANES        = 16,
    parameter int OS_SYMBOLS   = 16,
    parameter int SKEW_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [LANES*8-1:0]            laneData,
    input  logic [LANES-1:0]              laneValid,
    input  logic [LANES-1:0]              blockStart,
    input  logic [2*LANES-1:0]            syncHeader,
    input  logic [4:0]                    numberOfDetectedLanes,
    output logic [LANES*8*OS_SYMBOLS-1:0] orderedSets,
    output logic                          validOrderedSets,
    output logic [LANES-1:0]              laneError,
    output logic                          skewError
);
    localparam int SYM_W  = $clog2(OS_SYMBOLS);
    localparam int SKEW_W = $clog2(SKEW_TIMEOUT + 1);
    localparam int BLK_W  = 8 * OS_SYMBOLS;
    localparam logic [1:0] HDR_OS   = 2'b01;
    localparam logic [1:0] HDR_DATA = 2'b10;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} lane_state_e;

    lane_state_e      state_q [LANES];
    lane_state_e      state_d [LANES];
    logic [SYM_W-1:0] cnt_q   [LANES];
    logic [SYM_W-1:0] cnt_d   [LANES];
    logic [SYM_W-1:0] wr_idx  [LANES];
    logic [7:0]       lane_buf [LANES][OS_SYMBOLS];

    logic [LANES-1:0]       wr_en, lane_act, err_d;
    logic [4:0]             active_q, active;
    logic [SKEW_W-1:0]      skew_q, skew_d;
    logic                   all_idle, any_done, all_done, timeout, release_all, skp_set;
    logic [LANES*BLK_W-1:0] assembled;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < LANES; i++)
            if (state_q[i] != IDLE) all_idle = 1'b0;

        // The lane count may only change while no block is in flight.
        if (!all_idle)                                 active = active_q;
        else if (numberOfDetectedLanes > 5'(LANES))    active = 5'(LANES);
        else                                           active = numberOfDetectedLanes;

        lane_act = '0;
        any_done = 1'b0;
        all_done = (active != 5'd0);
        for (int i = 0; i < LANES; i++) begin
            lane_act[i] = (i < int'(active));
            if (lane_act[i]) begin
                if (state_q[i] == DONE) any_done = 1'b1;
                else                    all_done = 1'b0;
            end
        end

        timeout     = any_done && !all_done && (skew_q == SKEW_W'(SKEW_TIMEOUT));
        release_all = all_done || timeout;

        if (release_all)   skew_d = '0;
        else if (any_done) skew_d = skew_q + SKEW_W'(1);
        else               skew_d = skew_q;

        wr_en = '0;
        err_d = '0;
        for (int i = 0; i < LANES; i++) begin
            // On a release edge every lane behaves as IDLE, so a coinciding blockStart opens a new block.
            state_d[i] = release_all ? IDLE : state_q[i];
            cnt_d[i]   = cnt_q[i];
            wr_idx[i]  = cnt_q[i];
            if (lane_act[i] && laneValid[i]) begin
                case (state_d[i])
                    IDLE: begin
                        if (blockStart[i]) begin
                            if (syncHeader[2*i +: 2] == HDR_OS) begin
                                wr_en[i]   = 1'b1;
                                wr_idx[i]  = '0;
                                cnt_d[i]   = SYM_W'(1);
                                state_d[i] = COLLECT;
                            end else if (syncHeader[2*i +: 2] != HDR_DATA) begin
                                err_d[i] = 1'b1;
                            end
                        end
                    end
                    COLLECT: begin
                        if (blockStart[i]) begin
                            err_d[i] = 1'b1;
                            if (syncHeader[2*i +: 2] == HDR_OS) begin
                                wr_en[i]  = 1'b1;
                                wr_idx[i] = '0;
                                cnt_d[i]  = SYM_W'(1);
                            end else begin
                                state_d[i] = IDLE;
                            end
                        end else begin
                            wr_en[i] = 1'b1;
                            cnt_d[i] = cnt_q[i] + SYM_W'(1);
                            if (cnt_q[i] == SYM_W'(OS_SYMBOLS - 1)) state_d[i] = DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assembled = '0;
        for (int i = 0; i < LANES; i++)
            for (int k = 0; k < OS_SYMBOLS; k++)
                if (lane_act[i]) assembled[BLK_W*i + 8*k +: 8] = lane_buf[i][k];

`ifdef RX_OS_SKP_FILTER_EN
        skp_set = (lane_buf[0][0] == 8'hAA);
`else
        skp_set = 1'b0;
`endif
    end

    // NOTE: state registers use non-blocking assignments; the combinational block above uses blocking ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            active_q         <= '0;
            skew_q           <= '0;
            orderedSets      <= '0;
            validOrderedSets <= 1'b0;
            laneError        <= '0;
            skewError        <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            active_q         <= active;
            skew_q           <= skew_d;
            validOrderedSets <= all_done && !skp_set;
            if (all_done && !skp_set) orderedSets <= assembled;
            laneError        <= err_d;
            skewError        <= timeout;
        end
    end

    // NOTE: the payload store has no reset; a lane reaches DONE only after rewriting every symbol.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (wr_en[i]) lane_buf[i][wr_idx[i]] <= laneData[8*i +: 8];
    end

endmodule

// File: tb/tb_rx_os_collector.sv
// Directed bench for rx_os_collector: alignment, skew, framing errors, lane clamping, SKP handling and reset.
module tb_rx_os_collector;
    localparam int LANES = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [LANES*8-1:0] laneData;
    logic [LANES-1:0]  laneValid;
    logic [LANES-1:0]  blockStart;
    logic [2*LANES-1:0] syncHeader;
    logic [4:0]        numberOfDetectedLanes;
    logic [2047:0]     orderedSets;
    logic              validOrderedSets;
    logic [LANES-1:0]  laneError;
    logic              skewError;

    int n_checks = 0;
    int n_pass   = 0;
    int vcnt, vat, scnt, sat, ecnt, eat;
    logic [15:0]  eor;
    logic [15:0]  nv, nbs;
    logic [31:0]  nhdr;
    logic [127:0] nd;

    rx_os_collector dut (
        .clk                   (clk),
        .reset                 (reset),
        .laneData              (laneData),
        .laneValid             (laneValid),
        .blockStart            (blockStart),
        .syncHeader            (syncHeader),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .orderedSets           (orderedSets),
        .validOrderedSets      (validOrderedSets),
        .laneError             (laneError),
        .skewError             (skewError)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] lane_byte(input int i, input int k, input logic [7:0] b0);
        logic [3:0] li;
        logic [3:0] lk;
        li = 4'(i);
        lk = 4'(k);
        return (k == 0) ? b0 : {li, lk};
    endfunction

    function automatic logic [2047:0] exp_os(input int n, input logic [7:0] b0);
        logic [2047:0] e;
        e = '0;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 16; k++)
                e[128*i + 8*k +: 8] = lane_byte(i, k, b0);
        return e;
    endfunction

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass += 1;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_bus(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
        int l;
        n_checks++;
        assert (obs === exp) n_pass += 1;
        else begin
            l = 0;
            for (int i = 15; i >= 0; i--)
                if (obs[128*i +: 128] !== exp[128*i +: 128]) l = i;
            $error("FAIL %s lane %0d: got %h expected %h", tag, l, obs[128*l +: 128], exp[128*l +: 128]);
        end
    endtask

    task automatic clear_in();
        nv = '0; nbs = '0; nhdr = '0; nd = '0;
    endtask

    task automatic clear_mon();
        vcnt = 0; vat = -1; scnt = 0; sat = -1; ecnt = 0; eat = -1; eor = '0;
    endtask

    // Stage symbol s of lane i (ignored outside 0..15).
    task automatic put(input int i, input int s, input logic [7:0] b);
        if (s >= 0 && s < 16) begin
            nv[i]           = 1'b1;
            nbs[i]          = (s == 0);
            nhdr[2*i +: 2]  = 2'b01;
            nd[8*i +: 8]    = b;
        end
    endtask

    task automatic step(input int c);
        laneValid  = nv;
        blockStart = nbs;
        syncHeader = nhdr;
        laneData   = nd;
        @(posedge clk);
        #1;
        if (validOrderedSets) begin vcnt++; vat = c; end
        if (skewError)        begin scnt++; sat = c; end
        if (laneError != '0)  begin ecnt++; eat = c; eor = eor | laneError; end
    endtask

    // All 16 lanes send one block starting at cycle 0; lag_lane starts lag cycles late.
    task automatic run_block(input int lag_lane, input int lag, input logic [7:0] b0, input int cycles);
        int s;
        clear_mon();
        for (int c = 0; c < cycles; c++) begin
            clear_in();
            for (int i = 0; i < 16; i++) begin
                s = (i == lag_lane) ? c - lag : c;
                put(i, s, lane_byte(i, s, b0));
            end
            step(c);
        end
    endtask

    initial begin
        reset = 1'b0;
        numberOfDetectedLanes = 5'd0;
        clear_in();
        clear_mon();
        step(0);
        step(1);
        check_bus("rst_os", orderedSets, '0);
        check_int("rst_valid", int'(validOrderedSets), 0);
        check_int("rst_lane_err", int'(laneError), 0);
        check_int("rst_skew_err", int'(skewError), 0);
        reset = 1'b1;
        step(2);

        // 16 lanes aligned
        numberOfDetectedLanes = 5'd16;
        run_block(-1, 0, 8'h1E, 18);
        check_int("t1_vcnt", vcnt, 1);
        check_int("t1_vat", vat, 16);
        check_bus("t1_os", orderedSets, exp_os(16, 8'h1E));
        check_int("t1_errs", ecnt + scnt, 0);

        // 4 lanes, lane 3 lags 3 cycles; lanes 4..15 driven but inactive
        numberOfDetectedLanes = 5'd4;
        run_block(3, 3, 8'h1E, 21);
        check_int("t2_vcnt", vcnt, 1);
        check_int("t2_vat", vat, 19);
        check_bus("t2_os", orderedSets, exp_os(4, 8'h1E));
        check_int("t2_errs", ecnt + scnt, 0);

        // lag of exactly SKEW_TIMEOUT still completes
        run_block(3, 8, 8'h2D, 26);
        check_int("t2b_vcnt", vcnt, 1);
        check_int("t2b_vat", vat, 24);
        check_int("t2b_scnt", scnt, 0);
        check_bus("t2b_os", orderedSets, exp_os(4, 8'h2D));

        // lane 2 lags 9 cycles: skew timeout, output untouched
        run_block(2, 9, 8'h3C, 27);
        check_int("t3_vcnt", vcnt, 0);
        check_int("t3_scnt", scnt, 1);
        check_int("t3_sat", sat, 24);
        check_bus("t3_os", orderedSets, exp_os(4, 8'h2D));
        run_block(-1, 0, 8'h4B, 18);
        check_int("t3b_vcnt", vcnt, 1);
        check_int("t3b_vat", vat, 16);
        check_int("t3b_scnt", scnt, 0);
        check_bus("t3b_os", orderedSets, exp_os(4, 8'h4B));

        // lane 1 restarts with a new block at symbol 7; aborted bytes are 8'hEE
        clear_mon();
        for (int c = 0; c < 25; c++) begin
            clear_in();
            for (int i = 0; i < 16; i++) begin
                if (i != 1)     put(i, c, lane_byte(i, c, 8'h5A));
                else if (c < 7) put(1, c, 8'hEE);
                else            put(1, c - 7, lane_byte(1, c - 7, 8'h5A));
            end
            step(c);
        end
        check_int("t4_ecnt", ecnt, 1);
        check_int("t4_eat", eat, 7);
        check_int("t4_eor", int'(eor), 2);
        check_int("t4_vcnt", vcnt, 1);
        check_int("t4_vat", vat, 23);
        check_bus("t4_os", orderedSets, exp_os(4, 8'h5A));

        // header 11 in IDLE: single error pulse
        clear_mon();
        clear_in();
        nv[2] = 1'b1; nbs[2] = 1'b1; nhdr[5:4] = 2'b11;
        step(0);
        check_int("t4_hdr11_err", int'(laneError), 16'h0004);
        clear_in();
        step(1);
        check_int("t4_hdr11_pulse", int'(laneError), 0);
        check_int("t4_hdr11_ecnt", ecnt, 1);

        // header 10 in IDLE: silently ignored
        clear_mon();
        clear_in();
        nv[0] = 1'b1; nbs[0] = 1'b1; nhdr[1:0] = 2'b10;
        step(0);
        clear_in();
        step(1);
        check_int("t4_hdr10_ecnt", ecnt, 0);
        check_int("t4_hdr10_vcnt", vcnt, 0);

        // zero active lanes: nothing emitted, no errors
        numberOfDetectedLanes = 5'd0;
        run_block(-1, 0, 8'h66, 18);
        clear_in();
        nv = '1; nbs = '1; nhdr = '1;
        step(18);
        clear_in();
        step(19);
        check_int("z_vcnt", vcnt, 0);
        check_int("z_ecnt", ecnt, 0);
        check_int("z_scnt", scnt, 0);
        check_bus("z_os", orderedSets, exp_os(4, 8'h5A));

        // count above LANES clamps to 16
        numberOfDetectedLanes = 5'd20;
        run_block(-1, 0, 8'h69, 18);
        check_int("clamp_vcnt", vcnt, 1);
        check_bus("clamp_os", orderedSets, exp_os(16, 8'h69));

        // SKP set
        numberOfDetectedLanes = 5'd4;
        run_block(-1, 0, 8'hAA, 18);
`ifdef RX_OS_SKP_FILTER_EN
        check_int("skp_vcnt", vcnt, 0);
        check_bus("skp_os", orderedSets, exp_os(16, 8'h69));
`else
        check_int("skp_vcnt", vcnt, 1);
        check_bus("skp_os", orderedSets, exp_os(4, 8'hAA));
`endif

        // reset asserted at symbol 9
        clear_mon();
        for (int c = 0; c < 9; c++) begin
            clear_in();
            for (int i = 0; i < 16; i++) put(i, c, lane_byte(i, c, 8'h77));
            step(c);
        end
        clear_in();
        for (int i = 0; i < 16; i++) put(i, 9, lane_byte(i, 9, 8'h77));
        reset = 1'b0;
        step(9);
        check_bus("mrst_os", orderedSets, '0);
        check_int("mrst_valid", int'(validOrderedSets), 0);
        check_int("mrst_skew", int'(skewError), 0);
        reset = 1'b1;
        clear_in();
        step(10);
        run_block(-1, 0, 8'h1E, 18);
        check_int("post_rst_vcnt", vcnt, 1);
        check_int("post_rst_vat", vat, 16);
        check_int("post_rst_ecnt", ecnt, 0);
        check_bus("post_rst_os", orderedSets, exp_os(4, 8'h1E));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
